// File: rtl/dual_issue_buffer.sv
// dual_issue_buffer: in-order capture buffer with MIPS pairing rules, registered issue slots and queue request.
// Define DUAL_ISSUE_EN to allow two issues per cycle; when undefined at most one instruction issues.
module dual_issue_buffer #(
    parameter int BUF_DEPTH = 4,
    parameter int CP_W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush_i,
    input  logic                          ready_i,
    input  logic [1:0]                    IQ_supplyValid_i,
    input  logic [63:0]                   IQ_inst_p_i,
    input  logic [63:0]                   IQ_VAddr_p_i,
    input  logic [1:0]                    IQ_hasException_p_i,
    input  logic [9:0]                    IQ_ExcCode_p_i,
    input  logic [1:0]                    IQ_isRefill_p_i,
    input  logic [63:0]                   IQ_predDest_p_i,
    input  logic [1:0]                    IQ_predTake_p_i,
    input  logic [2*CP_W-1:0]             IQ_checkPoint_p_i,
    output logic [1:0]                    ID_upDateMode_o,
    output logic [1:0]                    ISS_valid_o,
    output logic [63:0]                   ISS_inst_p_o,
    output logic [63:0]                   ISS_VAddr_p_o,
    output logic [63:0]                   ISS_predDest_p_o,
    output logic [1:0]                    ISS_hasException_p_o,
    output logic [1:0]                    ISS_isRefill_p_o,
    output logic [1:0]                    ISS_predTake_p_o,
    output logic [9:0]                    ISS_ExcCode_p_o,
    output logic [2*CP_W-1:0]             ISS_checkPoint_p_o,
    output logic [$clog2(BUF_DEPTH):0]    buf_count_o
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int OW = AW + 2;
    localparam logic [4:0] NOEXCCODE = 5'h1f;

    typedef struct packed {
        logic [31:0]     vaddr;
        logic [31:0]     inst;
        logic [31:0]     pdest;
        logic            ptake;
        logic [CP_W-1:0] cp;
        logic            exc;
        logic [4:0]      code;
        logic            refill;
    } entry_t;

    entry_t        r_buf [BUF_DEPTH];
    logic [AW:0]   r_head;
    logic [AW:0]   r_tail;
    logic          r_shadow;
    logic [AW:0]   w_count;
    logic [AW-1:0] w_hidx1;
    logic [AW-1:0] w_tidx1;
    logic [1:0]    w_inc;
    logic [1:0]    w_n;
    logic          w_block;
    logic          w_wait;
    logic          w_single;
    logic [OW-1:0] w_occ;
    logic [OW-1:0] w_free;
    entry_t        w_e0;
    entry_t        w_e1;
    entry_t        w_s0;
    entry_t        w_s1;

    function automatic logic f_branch(input logic [31:0] i);
        return (i[31:26] == 6'h00 && i[5:1] == 5'b00100) || i[31:26] == 6'h01 ||
               i[31:28] == 4'b0001 || i[31:27] == 5'b00001 || i[31:28] == 4'b0101;
    endfunction

    function automatic logic f_priv(input logic [31:0] i);
        return i[31:26] == 6'h10 || i[31:26] == 6'h2f || (i[31:26] == 6'h00 && i[5:1] == 5'b00110);
    endfunction

    function automatic logic f_hilo(input logic [31:0] i);
        return i[31:26] == 6'h00 && (i[5:2] == 4'b0100 || i[5:2] == 4'b0110);
    endfunction

    // Link registers are written by JAL and the REGIMM and-link branches.
    function automatic logic [4:0] f_dest(input logic [31:0] i);
        return i[31:26] == 6'h00 ? i[15:11] :
               (i[31:26] == 6'h03 || (i[31:26] == 6'h01 && i[20:17] == 4'b1000)) ? 5'd31 :
               (i[31:29] == 3'b001 || i[31:29] == 3'b100 || i[31:26] == 6'h30 ||
                (i[31:26] == 6'h10 && i[25:21] == 5'd0)) ? i[20:16] : 5'd0;
    endfunction

    function automatic logic f_raw(input logic [31:0] p, input logic [31:0] c);
        return f_dest(p) != 5'd0 && (c[25:21] == f_dest(p) || c[20:16] == f_dest(p));
    endfunction

    assign w_s0 = '{vaddr: IQ_VAddr_p_i[31:0], inst: IQ_inst_p_i[31:0], pdest: IQ_predDest_p_i[31:0],
                    ptake: IQ_predTake_p_i[0], cp: IQ_checkPoint_p_i[CP_W-1:0], exc: IQ_hasException_p_i[0],
                    code: IQ_ExcCode_p_i[4:0], refill: IQ_isRefill_p_i[0]};
    assign w_s1 = '{vaddr: IQ_VAddr_p_i[63:32], inst: IQ_inst_p_i[63:32], pdest: IQ_predDest_p_i[63:32],
                    ptake: IQ_predTake_p_i[1], cp: IQ_checkPoint_p_i[2*CP_W-1:CP_W], exc: IQ_hasException_p_i[1],
                    code: IQ_ExcCode_p_i[9:5], refill: IQ_isRefill_p_i[1]};
    assign buf_count_o = w_count;

    always_comb begin
        w_count = r_tail - r_head;
        w_hidx1 = r_head[AW-1:0] + AW'(1);
        w_tidx1 = r_tail[AW-1:0] + AW'(1);
        w_e0 = r_buf[r_head[AW-1:0]];
        w_e1 = r_buf[w_hidx1];
        w_inc = (flush_i || r_shadow) ? 2'd0 : IQ_supplyValid_i == 2'b11 ? 2'd2 :
                IQ_supplyValid_i == 2'b01 ? 2'd1 : 2'd0;
        w_block = !ready_i || w_count == 0 || flush_i || r_shadow;
        w_wait = f_branch(w_e0.inst) && !w_e0.exc && w_count < 2;
`ifdef DUAL_ISSUE_EN
        w_single = w_count < 2 || f_priv(w_e0.inst) || f_priv(w_e1.inst) || w_e0.exc || w_e1.exc ||
                   f_branch(w_e1.inst) || f_raw(w_e0.inst, w_e1.inst) ||
                   (f_hilo(w_e0.inst) && f_hilo(w_e1.inst)) || (w_e0.inst[31] && w_e1.inst[31]);
`else
        w_single = 1'b1;
`endif
        w_n = (w_block || w_wait) ? 2'd0 : w_single ? 2'd1 : 2'd2;
        w_occ = OW'(w_count) + OW'(w_inc) - OW'(w_n);
        w_free = OW'(BUF_DEPTH) - w_occ;
        ID_upDateMode_o = (!rst || flush_i || r_shadow) ? 2'b00 : w_free >= 2 ? 2'b11 :
                          w_free == 1 ? 2'b01 : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (w_inc != 2'd0)
            r_buf[r_tail[AW-1:0]] <= w_s0;
        if (w_inc == 2'd2)
            r_buf[w_tidx1] <= w_s1;
    end

    // The request already reserves room for the next supply, so this can only fire on a queue bug.
    always_ff @(posedge clk) begin
        if (rst)
            assert (OW'(w_count) + OW'(w_inc) <= OW'(BUF_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head               <= '0;
            r_tail               <= '0;
            r_shadow             <= 1'b0;
            ISS_valid_o          <= 2'b00;
            ISS_inst_p_o         <= '0;
            ISS_VAddr_p_o        <= '0;
            ISS_predDest_p_o     <= '0;
            ISS_hasException_p_o <= '0;
            ISS_isRefill_p_o     <= '0;
            ISS_predTake_p_o     <= '0;
            ISS_ExcCode_p_o      <= {2{NOEXCCODE}};
            ISS_checkPoint_p_o   <= '0;
        end else if (flush_i) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_shadow    <= 1'b1;
            ISS_valid_o <= 2'b00;
        end else begin
            r_shadow <= 1'b0;
            r_head   <= r_head + (AW+1)'(w_n);
            r_tail   <= r_tail + (AW+1)'(w_inc);
            if (ready_i) begin
                ISS_valid_o          <= {w_n == 2'd2, w_n != 2'd0};
                ISS_inst_p_o         <= {w_e1.inst, w_e0.inst};
                ISS_VAddr_p_o        <= {w_e1.vaddr, w_e0.vaddr};
                ISS_predDest_p_o     <= {w_e1.pdest, w_e0.pdest};
                ISS_hasException_p_o <= {w_e1.exc, w_e0.exc};
                ISS_isRefill_p_o     <= {w_e1.refill, w_e0.refill};
                ISS_predTake_p_o     <= {w_e1.ptake, w_e0.ptake};
                ISS_ExcCode_p_o      <= {w_e1.code, w_e0.code};
                ISS_checkPoint_p_o   <= {w_e1.cp, w_e0.cp};
            end
        end
    end
endmodule

// File: tb/tb_dual_issue_buffer.sv
// tb_dual_issue_buffer: directed stimulus with an issue scoreboard for dual_issue_buffer.
module tb_dual_issue_buffer;
`ifdef DUAL_ISSUE_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif
    localparam logic [31:0] NOP = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush_i = 1'b0;
    logic        ready_i = 1'b1;
    logic [1:0]  sv = 2'b00;
    logic [63:0] inst = '0;
    logic [63:0] vaddr = '0;
    logic [63:0] pdest = '0;
    logic [1:0]  exc = '0;
    logic [9:0]  code = '0;
    logic [1:0]  refill = '0;
    logic [1:0]  ptake = '0;
    logic [15:0] cp = '0;
    logic [1:0]  mode;
    logic [1:0]  iss_v;
    logic [63:0] iss_inst;
    logic [63:0] iss_va;
    logic [63:0] iss_pd;
    logic [1:0]  iss_exc;
    logic [1:0]  iss_ref;
    logic [1:0]  iss_pt;
    logic [9:0]  iss_code;
    logic [15:0] iss_cp;
    logic [2:0]  cnt;

    typedef struct {
        logic [1:0]  v;
        logic [31:0] i0;
        logic [31:0] a0;
        logic [31:0] i1;
        logic [31:0] a1;
        logic        x0;
        logic [4:0]  c0;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   checks = 0;
    int   errors = 0;
    logic loaded = 1'b0;

    dual_issue_buffer #(.BUF_DEPTH(4), .CP_W(8)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .ready_i(ready_i),
        .IQ_supplyValid_i(sv), .IQ_inst_p_i(inst), .IQ_VAddr_p_i(vaddr),
        .IQ_hasException_p_i(exc), .IQ_ExcCode_p_i(code), .IQ_isRefill_p_i(refill),
        .IQ_predDest_p_i(pdest), .IQ_predTake_p_i(ptake), .IQ_checkPoint_p_i(cp),
        .ID_upDateMode_o(mode), .ISS_valid_o(iss_v), .ISS_inst_p_o(iss_inst),
        .ISS_VAddr_p_o(iss_va), .ISS_predDest_p_o(iss_pd), .ISS_hasException_p_o(iss_exc),
        .ISS_isRefill_p_o(iss_ref), .ISS_predTake_p_o(iss_pt), .ISS_ExcCode_p_o(iss_code),
        .ISS_checkPoint_p_o(iss_cp), .buf_count_o(cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] r(input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] it(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    always @(posedge clk) loaded <= rst && ready_i && !flush_i;

    always @(negedge clk) begin
        if (loaded && iss_v != 2'b00) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL issue: unexpected v=%b inst0=%h va0=%h, expected nothing", iss_v, iss_inst[31:0], iss_va[31:0]);
            end else begin
                me = sb.pop_front();
                if (iss_v != me.v || iss_inst[31:0] != me.i0 || iss_va[31:0] != me.a0 ||
                    iss_exc[0] != me.x0 || iss_code[4:0] != me.c0 ||
                    (me.v[1] && (iss_inst[63:32] != me.i1 || iss_va[63:32] != me.a1))) begin
                    errors++;
                    $display("FAIL issue: got v=%b %h@%h %h@%h x=%b c=%h, expected v=%b %h@%h %h@%h x=%b c=%h",
                             iss_v, iss_inst[31:0], iss_va[31:0], iss_inst[63:32], iss_va[63:32], iss_exc[0], iss_code[4:0],
                             me.v, me.i0, me.a0, me.i1, me.a1, me.x0, me.c0);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [31:0] i0 = 0, input logic [31:0] a0 = 0,
                         input logic [31:0] i1 = 0, input logic [31:0] a1 = 0,
                         input logic x0 = 0, input logic [4:0] c0 = 0);
        @(negedge clk);
        sv = v;
        inst = {i1, i0};
        vaddr = {a1, a0};
        pdest = {a1 + 32'd8, a0 + 32'd8};
        exc = {1'b0, x0};
        code = {5'd0, c0};
    endtask

    task automatic exp1(input logic [31:0] i, input logic [31:0] a, input logic x = 0, input logic [4:0] c = 0);
        sb.push_back('{v: 2'b01, i0: i, a0: a, i1: 32'd0, a1: 32'd0, x0: x, c0: c});
    endtask

    task automatic exp2(input logic [31:0] i0, input logic [31:0] a0, input logic [31:0] i1, input logic [31:0] a1);
        if (DUAL)
            sb.push_back('{v: 2'b11, i0: i0, a0: a0, i1: i1, a1: a1, x0: 1'b0, c0: 5'd0});
        else begin
            exp1(i0, a0);
            exp1(i1, a1);
        end
    endtask

    task automatic drain();
        int n = 0;
        drive(2'b00);
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d issues outstanding, expected 0", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", iss_v, 2'b00);
        chk("rst_mode", mode, 2'b00);
        chk("rst_exccode", iss_code, 10'h3ff);
        chk("rst_inst", iss_inst[31:0], 32'h0);
        chk("rst_count", cnt, 3'd0);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("idle_mode", mode, 2'b11);
        // independent ADDU pair and issue latency
        drive(2'b11, r(6'h21, 5'd2, 5'd3, 5'd1), 32'h100, r(6'h21, 5'd5, 5'd6, 5'd4), 32'h104);
        exp2(r(6'h21, 5'd2, 5'd3, 5'd1), 32'h100, r(6'h21, 5'd5, 5'd6, 5'd4), 32'h104);
        drive(2'b00);
        chk("t1_lat1", iss_v, 2'b00);
        @(negedge clk);
        chk("t1_lat2", iss_v, DUAL ? 2'b11 : 2'b01);
        drain();
        // RAW split
        drive(2'b11, r(6'h21, 5'd2, 5'd3, 5'd1), 32'h110, r(6'h23, 5'd1, 5'd5, 5'd4), 32'h114);
        exp1(r(6'h21, 5'd2, 5'd3, 5'd1), 32'h110);
        exp1(r(6'h23, 5'd1, 5'd5, 5'd4), 32'h114);
        drive(2'b00);
        repeat (2) @(negedge clk);
        chk("t2_second", iss_inst[31:0], r(6'h23, 5'd1, 5'd5, 5'd4));
        drain();
        // branch waits for its delay slot
        drive(2'b01, it(6'h04, 5'd1, 5'd2, 16'h4), 32'h300);
        drive(2'b01, NOP, 32'h304);
        exp2(it(6'h04, 5'd1, 5'd2, 16'h4), 32'h300, NOP, 32'h304);
        drive(2'b00);
        chk("t3_wait", iss_v, 2'b00);
        @(negedge clk);
        chk("t3_pair", iss_v, DUAL ? 2'b11 : 2'b01);
        chk("t3_slot0", iss_inst[31:0], it(6'h04, 5'd1, 5'd2, 16'h4));
        drain();
        // fill with ready low, then release
        drive(2'b00);
        ready_i = 1'b0;
        #1 chk("t4_mode0", mode, 2'b11);
        drive(2'b11, r(6'h21, 5'd2, 5'd3, 5'd8), 32'h400, r(6'h21, 5'd2, 5'd3, 5'd9), 32'h404);
        #1 chk("t4_mode1", mode, 2'b11);
        drive(2'b11, r(6'h21, 5'd2, 5'd3, 5'd10), 32'h408, r(6'h21, 5'd2, 5'd3, 5'd11), 32'h40c);
        #1 chk("t4_mode2", mode, 2'b00);
        drive(2'b00);
        #1 chk("t4_mode3", mode, 2'b00);
        chk("t4_full", cnt, 3'd4);
        exp2(r(6'h21, 5'd2, 5'd3, 5'd8), 32'h400, r(6'h21, 5'd2, 5'd3, 5'd9), 32'h404);
        exp2(r(6'h21, 5'd2, 5'd3, 5'd10), 32'h408, r(6'h21, 5'd2, 5'd3, 5'd11), 32'h40c);
        ready_i = 1'b1;
        #1 chk("t4_release_mode", mode, DUAL ? 2'b11 : 2'b01);
        drain();
        // flush with buffered entries and a supply in flight
        drive(2'b01, r(6'h21, 5'd2, 5'd3, 5'd12), 32'h500);
        exp1(r(6'h21, 5'd2, 5'd3, 5'd12), 32'h500);
        drive(2'b11, r(6'h21, 5'd2, 5'd3, 5'd13), 32'h504, r(6'h21, 5'd2, 5'd3, 5'd14), 32'h508);
        drive(2'b01, r(6'h21, 5'd2, 5'd3, 5'd15), 32'h50c);
        ready_i = 1'b0;
        #1 chk("t5_mode_one", mode, 2'b01);
        chk("t5_count2", cnt, 3'd2);
        chk("t5_iss_x", iss_v, 2'b01);
        drive(2'b01, r(6'h21, 5'd2, 5'd3, 5'd16), 32'h510);
        flush_i = 1'b1;
        #1 chk("t5_flush_mode", mode, 2'b00);
        chk("t5_count3", cnt, 3'd3);
        chk("t5_hold", iss_v, 2'b01);
        drive(2'b11, r(6'h21, 5'd2, 5'd3, 5'd17), 32'h514, r(6'h21, 5'd2, 5'd3, 5'd18), 32'h518);
        flush_i = 1'b0;
        #1 chk("t5_flushed_valid", iss_v, 2'b00);
        chk("t5_flushed_count", cnt, 3'd0);
        chk("t5_shadow_mode", mode, 2'b00);
        drive(2'b00);
        ready_i = 1'b1;
        #1 chk("t5_shadow_drop", cnt, 3'd0);
        chk("t5_recover_mode", mode, 2'b11);
        drive(2'b01, r(6'h21, 5'd2, 5'd3, 5'd19), 32'h520);
        exp1(r(6'h21, 5'd2, 5'd3, 5'd19), 32'h520);
        drain();
        // HI/LO, memory, serialising and exception pairs each split
        drive(2'b11, r(6'h18, 5'd2, 5'd3, 5'd0), 32'h600, r(6'h12, 5'd0, 5'd0, 5'd7), 32'h604);
        exp1(r(6'h18, 5'd2, 5'd3, 5'd0), 32'h600);
        exp1(r(6'h12, 5'd0, 5'd0, 5'd7), 32'h604);
        drain();
        drive(2'b11, it(6'h2b, 5'd2, 5'd1, 16'h0), 32'h610, it(6'h23, 5'd5, 5'd3, 16'h4), 32'h614);
        exp1(it(6'h2b, 5'd2, 5'd1, 16'h0), 32'h610);
        exp1(it(6'h23, 5'd5, 5'd3, 16'h4), 32'h614);
        drain();
        drive(2'b11, 32'h0000000c, 32'h620, r(6'h21, 5'd2, 5'd3, 5'd9), 32'h624);
        exp1(32'h0000000c, 32'h620);
        exp1(r(6'h21, 5'd2, 5'd3, 5'd9), 32'h624);
        drain();
        drive(2'b11, r(6'h21, 5'd2, 5'd3, 5'd10), 32'h630, r(6'h21, 5'd2, 5'd3, 5'd11), 32'h634, 1'b1, 5'h0a);
        exp1(r(6'h21, 5'd2, 5'd3, 5'd10), 32'h630, 1'b1, 5'h0a);
        exp1(r(6'h21, 5'd2, 5'd3, 5'd11), 32'h634);
        drain();
        // branch in the second slot issues later with its delay slot
        drive(2'b11, r(6'h21, 5'd2, 5'd3, 5'd12), 32'h640, it(6'h05, 5'd2, 5'd3, 16'h8), 32'h644);
        drive(2'b01, NOP, 32'h648);
        exp1(r(6'h21, 5'd2, 5'd3, 5'd12), 32'h640);
        exp2(it(6'h05, 5'd2, 5'd3, 16'h8), 32'h644, NOP, 32'h648);
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dual_issue_buffer.md
Name: dual_issue_buffer

Overview:
- Consumer of the instruction queue's two-slot supply. Captures up to 2 supplied instructions per cycle into a small in-order buffer and applies MIPS dual-issue pairing rules.
- Drives registered issue slots to the register-read stage.
- Generates the queue's per-cycle request (ID_upDateMode_o) so that supplied instructions, which the queue retires unconditionally, always have room.

Parameters:
- BUF_DEPTH, 4: buffer entries (power of 2, ≥4).
- CP_W, 8: branch checkpoint width per instruction.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- flush_i  in  1  pipeline flush (mispredict/exception)
- ready_i  in  1  register-read stage accepts issue this cycle
- IQ_supplyValid_i  in  2  valid per supplied slot (00/01/11)
- IQ_inst_p_i  in  64  instructions; slot0 in [31:0]
- IQ_VAddr_p_i  in  64  PCs
- IQ_hasException_p_i  in  2  fetch exception flags
- IQ_ExcCode_p_i  in  10  5-bit codes
- IQ_isRefill_p_i  in  2  TLB refill flags
- IQ_predDest_p_i  in  64  predicted targets
- IQ_predTake_p_i  in  2  predicted taken
- IQ_checkPoint_p_i  in  2*CP_W  checkpoints
- ID_upDateMode_o  out  2  request to queue: 00/01/11
- ISS_valid_o  out  2  issued slot valid
- ISS_inst_p_o, ISS_VAddr_p_o, ISS_predDest_p_o  out  64 each  issued fields
- ISS_hasException_p_o, ISS_isRefill_p_o, ISS_predTake_p_o  out  2 each
- ISS_ExcCode_p_o  out  10
- ISS_checkPoint_p_o  out  2*CP_W
- buf_count_o  out  log2(BUF_DEPTH)+1  occupied entries

Behaviour:
- Entry = {VAddr, inst, predDest, predTake, checkPoint, hasExc, ExcCode, isRefill}. Circular buffer with head/tail pointers one bit wider than the index; count = tail−head, modulo wrap.
- Enqueue: slot0 then slot1, for each bit of IQ_supplyValid_i that is set. Supply 10 never occurs; treat it as 00.
- Issue candidates are the entries at head and head+1 (E0, E1). Issue count n is evaluated in priority order:
  - n=0 if !ready_i, count==0, or a shadow/flush condition is active.
  - n=0 if E0 is a branch/jump, E0 has no exception, and E1 is not present (wait for the delay slot).
  - n=1 if E0 or E1 is a privileged/serialising op (COP0, ERET, SYSCALL, BREAK, CACHE, TLB*) or has hasExc.
  - n=1 if E1 is a branch/jump.
  - n=1 if E1 reads E0's destination register. Dest is rd for R-type, rt for I-type ALU/LUI/load/MFC0, and 31 for JAL/BGEZAL/BLTZAL; register 0 is ignored. Sources are rs/rt as encoded.
  - n=1 if both E0 and E1 are HI/LO class (MULT*/DIV*/MTHI/MTLO/MFHI/MFLO).
  - n=1 if both are memory ops.
  - Otherwise n=min(count,2). A branch at E0 with E1 present issues both.
- Issue regs: on ready_i, ISS_valid_o <= {n==2, n≥1} and fields <= E0/E1 (E1 fields are don't-care when not valid). On !ready_i, all ISS_* hold. head += n. Latency: an instruction supplied in cycle t is issuable in t+1 and appears on ISS_* in t+2 at the earliest.
- Request: occ = count + incoming − n (next-cycle occupancy). ID_upDateMode_o = 11 if BUF_DEPTH−occ ≥ 2, 01 if = 1, 00 if 0. This is registered-free combinational from state and inputs. At most one request is in flight, so overflow is impossible; a supply that would overflow is a design error and must be asserted in simulation.
- Flush: in the same cycle, head/tail are cleared, incoming supply is discarded, ISS_valid_o <= 00 regardless of ready_i, and ID_upDateMode_o = 00. The supply arriving in the cycle after a flush (in-flight request) is also discarded via a 1-cycle shadow flag; the request is 00 during the shadow.
- Simultaneous supply + issue + flush: flush wins.
- Reset: head, tail, and the shadow flag are 0; ISS_valid_o = 00; all ISS_* data = 0 except ExcCode = NOEXCCODE; ID_upDateMode_o = 00 while rst is low. Reset asserted mid-operation drops all buffered entries.

Optional Feature:
- DUAL_ISSUE_EN defined: pairing rules above apply, and up to 2 instructions issue per cycle.
- Undefined: n ≤ 1 always; ISS_valid_o[1] is constantly 0. A branch at E0 still waits for its delay slot to be buffered but issues alone, with the delay slot following in the next issue cycle. Request logic is unchanged.

Test Plan:
- Reset; supply 11 with ADDU $1,$2,$3 / ADDU $4,$5,$6, ready=1 → ISS_valid=11 two cycles later; both inst/VAddr match.
- Supply ADDU $1,$2,$3 / SUBU $4,$1,$5 → issue 01 then 01 on consecutive cycles (RAW split).
- Supply 01 with BEQ alone, then 01 with delay slot NOP one cycle later → no issue until the NOP arrives, then ISS_valid=11 (BEQ slot0).
- Hold ready=0 while supplying 11 every cycle → ID_upDateMode_o falls 11→11→00 as count reaches 4; no overflow; on releasing ready, issue resumes in order with VAddr strictly increasing by 4.
- flush_i with 3 buffered entries and supply 11 in flight → ISS_valid=00 next cycle; the shadow-cycle supply is dropped; buf_count_o=0.
- Supply MULT / MFLO, and in a separate run SW / LW pair → each pair issues single-slot over 2 cycles; without DUAL_ISSUE_EN, an independent ADDU pair also issues over 2 cycles.
